// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
// Shared constants for the SRAM controller slice: FSM state encoding, default
// timing / address-map parameters, SRAM bus widths and the halfword address
// helper used by the controller.
// -----------------------------------------------------------------------------
package sram_controller_pkg;

   // SRAM bus geometry
   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_ADDR_W = 18;

   // Width of the per-phase wait counter (WAIT_CYCLES legal range 1..15)
   localparam int CNT_W = 4;

   // Parameter defaults for sram_controller
   localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
   localparam logic [31:0] DEFAULT_MEM_BASE    = 32'd1024;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // A 32-bit word occupies two consecutive SRAM halfwords: the word index
   // forms the upper address bits and bit 0 selects the low/high half.
   function automatic logic [SRAM_ADDR_W-1:0] halfword_addr(
      input logic [SRAM_ADDR_W-2:0] word_index,
      input logic                   hi_half
   );
      return {word_index, hi_half};
   endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// 4-bit loadable down-counter with a zero flag. Holds at zero; load wins over
// decrement.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears count
//   load       : load load_value this cycle
//   load_value : value to load
//   dec        : decrement when count is non-zero
//   count      : current count
//   zero       : count == 0
// -----------------------------------------------------------------------------
module wait_counter
   import sram_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Bridges a 32-bit MEM-stage load/store port to a 16-bit asynchronous SRAM.
// Each access is two halfword phases (LO then HI), each WAIT_CYCLES long.
//
// Handshake: a request (rd_en or wr_en) is accepted in the IDLE cycle in which
// it is seen; ready is combinational and is 1 only in IDLE with no request or
// in the single DONE cycle, so the pipeline stalls from the accepting cycle
// until DONE. Inputs after acceptance are ignored until the next IDLE.
//
// Ports:
//   clk, rst            : clock / synchronous active-high reset
//   rd_en, wr_en        : load / store request (store wins if both set)
//   address, write_data : byte address and store data
//   read_data, ready    : load result (held until next read completes), stall
//   SRAM_DQ             : bidirectional 16-bit SRAM data bus
//   SRAM_ADDR           : SRAM halfword address
//   SRAM_WE_N           : active-low write strobe
//   SRAM_UB_N/LB_N/CE_N/OE_N : tied low
// -----------------------------------------------------------------------------
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

   logic [1:0]             state;
   logic [1:0]             state_next;
   logic                   op_write_q;
   logic [31:0]            addr_q;
   logic [31:0]            wdata_q;
   logic [31:0]            rdata_q;
   logic [SRAM_DATA_W-1:0] rdata_lo_q;

   logic                   request;
   logic                   in_phase;
   logic                   cnt_load;
   logic                   cnt_dec;
   logic [CNT_W-1:0]       cnt;
   logic                   cnt_zero;
   logic [31:0]            offset;
   logic                   drive_dq;
   logic [SRAM_DATA_W-1:0] dq_out;
   logic                   unused_offset_bits;

   assign request  = rd_en | wr_en;
   assign in_phase = (state == ST_LO) || (state == ST_HI);

   // Counter is (re)loaded on accept and on the LO->HI boundary so each phase
   // lasts exactly WAIT_CYCLES cycles.
   assign cnt_load = ((state == ST_IDLE) && request) || ((state == ST_LO) && cnt_zero);
   assign cnt_dec  = in_phase && !cnt_zero;

   wait_counter u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (RELOAD),
      .dec        (cnt_dec),
      .count      (cnt),
      .zero       (cnt_zero)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (request)  state_next = ST_LO;
         ST_LO:   if (cnt_zero) state_next = ST_HI;
         ST_HI:   if (cnt_zero) state_next = ST_DONE;
         ST_DONE:               state_next = ST_IDLE;
         default:               state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rdata_lo_q <= '0;
      end else begin
         state <= state_next;
         if ((state == ST_IDLE) && request) begin
            op_write_q <= wr_en;
            addr_q     <= address;
            wdata_q    <= write_data;
         end
         // The low half is staged separately so read_data only changes when
         // the whole word has been fetched.
         if ((state == ST_LO) && cnt_zero && !op_write_q) begin
            rdata_lo_q <= SRAM_DQ;
         end
         if ((state == ST_HI) && cnt_zero && !op_write_q) begin
            rdata_q <= {SRAM_DQ, rdata_lo_q};
         end
      end
   end

   // Addresses below MEM_BASE simply wrap; only offset[18:2] reaches the SRAM.
   assign offset             = addr_q - MEM_BASE;
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
   assign SRAM_ADDR          = halfword_addr(offset[18:2], state == ST_HI);

   assign drive_dq  = op_write_q && in_phase;
   assign dq_out    = (state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
   assign SRAM_DQ   = drive_dq ? dq_out : {SRAM_DATA_W{1'bz}};
   assign SRAM_WE_N = !drive_dq;

   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

   assign read_data = rdata_q;
   assign ready     = ((state == ST_IDLE) && !request) || (state == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Directed bench for sram_controller with a small SRAM model on the data bus.
// Write beats and load results are queued when a request is issued and popped
// when the controller puts a beat on the bus or raises ready.
// -----------------------------------------------------------------------------
module tb_sram_controller;
   import sram_controller_pkg::*;

   localparam int unsigned W    = 2;
   localparam logic [31:0] BASE = 32'd1024;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(W), .MEM_BASE(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .SRAM_DQ    (sram_dq),
      .SRAM_ADDR  (sram_addr),
      .SRAM_WE_N  (sram_we_n),
      .SRAM_UB_N  (sram_ub_n),
      .SRAM_LB_N  (sram_lb_n),
      .SRAM_CE_N  (sram_ce_n),
      .SRAM_OE_N  (sram_oe_n)
   );

   // ---------------- SRAM model ----------------
   // Undriven bus floats to all-ones so a released bus is observable.
   logic model_en = 1'b0;
   logic mon_on   = 1'b0;

   function automatic logic [15:0] model_word(input logic [17:0] a);
      case (a)
         18'd2:   return 16'h1234;
         18'd3:   return 16'hABCD;
         default: return a[15:0] ^ 16'h5A5A;
      endcase
   endfunction

   pullup pu_dq (sram_dq);
   assign sram_dq = (model_en && sram_we_n) ? model_word(sram_addr) : 16'bz;

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [33:0] exp_bus_q[$];
   logic [31:0] last_rd = '0;

   task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor: every write beat must match the queue head; whenever the
   // controller is not writing and the model is off, the bus must be released.
   always @(negedge clk) begin
      if (mon_on) begin
         if (sram_we_n === 1'b0) begin
            checks++;
            assert (exp_bus_q.size() > 0) else begin
               errors++;
               $error("FAIL unexpected_write_beat observed=%0h expected=none", {sram_addr, sram_dq});
            end
            if (exp_bus_q.size() > 0) begin
               logic [33:0] exp_beat;
               exp_beat = exp_bus_q.pop_front();
               check({30'd0, sram_addr, sram_dq}, {30'd0, exp_beat}, "write_beat");
            end
         end else if (!model_en) begin
            check({48'd0, sram_dq}, 64'h0000_0000_0000_FFFF, "dq_released");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request in the current (IDLE) cycle, keep it for 'hold' cycles,
   // then scramble the inputs and wait for ready.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
      logic [31:0] off;
      logic [17:0] lo_a, hi_a;
      logic [31:0] exp_rd;
      int          n;
      bit          done;
      off  = addr - BASE;
      lo_a = {off[18:2], 1'b0};
      hi_a = {off[18:2], 1'b1};
      if (wr) begin
         for (int i = 0; i < int'(W); i++) exp_bus_q.push_back({lo_a, wdata[15:0]});
         for (int i = 0; i < int'(W); i++) exp_bus_q.push_back({hi_a, wdata[31:16]});
      end else begin
         exp_q.push_back(model_en ? {model_word(hi_a), model_word(lo_a)} : 32'hFFFF_FFFF);
      end
      rd_en      = rd;
      wr_en      = wr;
      address    = addr;
      write_data = wdata;
      @(negedge clk);
      check({63'd0, ready}, 64'd0, "ready_low_on_accept");
      n    = 0;
      done = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (n >= hold) begin
            rd_en      = 1'b0;
            wr_en      = 1'b0;
            address    = $urandom;
            write_data = $urandom;
         end
         @(negedge clk);
         if (ready) done = 1;
         else if (n <= int'(W)) check({46'd0, sram_addr}, {46'd0, lo_a}, "addr_lo");
         else check({46'd0, sram_addr}, {46'd0, hi_a}, "addr_hi");
      end
      check(64'(n), 64'(2 * W + 1), "latency");
      if (wr) begin
         check({32'd0, read_data}, {32'd0, last_rd}, "read_data_held");
      end else if (exp_q.size() > 0) begin
         exp_rd  = exp_q.pop_front();
         last_rd = exp_rd;
         check({32'd0, read_data}, {32'd0, exp_rd}, "read_data");
      end
      check(64'(exp_bus_q.size()), 64'd0, "write_beats_done");
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] ra;
      logic        rw;

      // reset
      rst = 1'b1;
      step(); step(); step();
      rst = 1'b0;
      @(negedge clk);
      check({63'd0, ready}, 64'd1, "reset_ready");
      check({32'd0, read_data}, 64'd0, "reset_read_data");
      check({63'd0, sram_we_n}, 64'd1, "reset_we_n");
      check({48'd0, sram_dq}, 64'h0000_0000_0000_FFFF, "reset_dq");
      mon_on = 1'b1;

      // read with model off: controller must never drive the bus
      step();
      access(1'b1, 1'b0, 32'd1028, 32'h0, 1);

      // read 1028 with SRAM contents 0x1234 @2, 0xABCD @3, request held into LO
      step();
      model_en = 1'b1;
      access(1'b1, 1'b0, 32'd1028, 32'h0, 2);

      // write DEADBEEF at 1024
      step();
      model_en = 1'b0;
      access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1);

      // both requests set: write wins, read_data untouched
      step();
      access(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 1);

      // back-to-back: read, read, write with no idle cycles between
      step();
      model_en = 1'b1;
      access(1'b1, 1'b0, 32'd1036, 32'h0, 1);
      step();
      access(1'b1, 1'b0, 32'd1040, 32'h0, 1);
      step();
      access(1'b0, 1'b1, 32'd1044, 32'h1234_5678, 1);

      // random mix in the first 1 KiB of the window
      for (int i = 0; i < 6; i++) begin
         step();
         ra = BASE + {20'd0, 8'($urandom_range(0, 255)), 2'b00};
         rw = 1'($urandom_range(0, 1));
         access(!rw, rw, ra, $urandom, $urandom_range(1, 2));
      end

      // below base: wrapped offset
      step();
      access(1'b1, 1'b0, 32'd1020, 32'h0, 1);
      check({32'd0, last_rd}, {32'd0, 32'hA5A5_A5A4}, "wrap_read_value");

      // reset during HI of a write
      step();
      model_en = 1'b0;
      exp_bus_q.push_back({18'd4, 16'hF00D});
      exp_bus_q.push_back({18'd4, 16'hF00D});
      exp_bus_q.push_back({18'd5, 16'hCAFE});
      exp_bus_q.push_back({18'd5, 16'hCAFE});
      wr_en      = 1'b1;
      address    = 32'd1032;
      write_data = 32'hCAFE_F00D;
      @(negedge clk);
      check({63'd0, ready}, 64'd0, "rst_case_accept");
      step();
      wr_en = 1'b0;
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      check({46'd0, sram_addr}, 64'd5, "rst_case_in_hi");
      step();
      rst = 1'b0;
      @(negedge clk);
      exp_bus_q.delete();
      check({63'd0, ready}, 64'd1, "rst_mid_ready");
      check({63'd0, sram_we_n}, 64'd1, "rst_mid_we_n");
      check({48'd0, sram_dq}, 64'h0000_0000_0000_FFFF, "rst_mid_dq");
      check({32'd0, read_data}, 64'd0, "rst_mid_read_data");
      last_rd = 32'd0;
      step();
      @(negedge clk);
      check({63'd0, ready}, 64'd1, "rst_mid_stays_idle");

      // controller resumes normal operation after the abandoned write
      step();
      model_en = 1'b1;
      access(1'b1, 1'b0, 32'd1028, 32'h0, 1);

      check({60'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 64'd0, "tie_offs");
      check(64'(exp_q.size()), 64'd0, "read_queue_empty");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: SRAM clock cycles held per halfword phase (legal 1..15).
REQ-002 SHALL have parameter MEM_BASE, default 1024: byte address mapped to SRAM halfword 0.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rd_en  input  1  MEM-stage load request (decoder mem_read).
REQ-007 wr_en  input  1  MEM-stage store request (decoder mem_write).
REQ-008 address  input  32  byte address from ALU result.
REQ-009 write_data  input  32  store data.
REQ-010 read_data  output  32  load data, valid while ready=1 after a read.
REQ-011 ready  output  1  0 stalls pipeline; 1 lets MEM stage advance.
REQ-012 SRAM_DQ  inout  16  SRAM data bus.
REQ-013 SRAM_ADDR  output  18  SRAM halfword address.
REQ-014 SRAM_WE_N  output  1  active-low write strobe.
REQ-015 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0 (always enabled).

Function
REQ-016 FSM states: IDLE, LO, HI, DONE.
REQ-017 IDLE: if wr_en|rd_en, latch op (wr_en has priority when both set), address, write_data; go LO with counter = WAIT_CYCLES-1.
REQ-018 LO/HI: counter decrements each cycle; at counter=0 LO->HI (counter reloaded), HI->DONE.
REQ-019 DONE: ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 ready SHALL be combinational: 1 in IDLE with no request, 1 in DONE, else 0 (including IDLE with request).
REQ-021 Latency: request seen in IDLE at cycle T -> ready=1 at cycle T+1+2*WAIT_CYCLES (T+5 at default).
REQ-022 Offset = (address - MEM_BASE) mod 2^32; SRAM_ADDR = {offset[18:2], 0} in LO, {offset[18:2], 1} in HI; upper offset bits and offset[1:0] ignored, no error.
REQ-023 Write: SRAM_WE_N=0 throughout LO and HI; SRAM_DQ drives write_data[15:0] in LO, [31:16] in HI.
REQ-024 Read: SRAM_WE_N=1, SRAM_DQ high-Z; SRAM_DQ sampled on last cycle of LO into read_data[15:0], of HI into read_data[31:16].
REQ-025 SRAM_DQ SHALL be high-Z in IDLE, DONE and all read phases; SRAM_WE_N=1 in IDLE and DONE.
REQ-026 Request deasserted or changed mid-access SHALL not affect the latched operation; it completes.
REQ-027 read_data SHALL hold its value until the next read completes; writes never modify it.
REQ-028 Back-to-back: request present in the IDLE cycle after DONE starts a new access with no extra idle cycle.

Reset
REQ-029 rst SHALL force IDLE, counter 0, read_data 0, latched op/address/data 0, SRAM_WE_N=1, SRAM_DQ high-Z, mid-access included; in-flight write is abandoned.
REQ-030 Reset value of ready SHALL follow REQ-020 (1 with no request).

Structure
REQ-031 Shared package SHALL hold state encoding (IDLE=0, LO=1, HI=2, DONE=3), MEM_BASE and WAIT_CYCLES defaults, SRAM width constants.
REQ-032 One sub-module, wait_counter (4-bit loadable down-counter with zero flag), is natural; FSM and bus drivers stay in sram_controller.

Verification
REQ-033 Write address=1024, data=0xDEADBEEF, WAIT=2 -> SRAM_ADDR 0 with DQ 0xBEEF for 2 cycles, then 1 with 0xDEAD for 2 cycles, WE_N low 4 cycles, ready=1 at T+5.
REQ-034 Read address=1028 with SRAM model holding 0x1234 at 2, 0xABCD at 3 -> read_data=0xABCD1234 at ready, DQ never driven.
REQ-035 rd_en and wr_en both set -> write performed, read_data unchanged.
REQ-036 rst asserted in HI of a write -> next cycle IDLE, WE_N=1, DQ high-Z, read_data=0, ready=1 with no request.
REQ-037 Request dropped after accept, then two back-to-back reads -> first completes; second starts in the IDLE cycle after DONE, ready pulses once per access.
REQ-038 address=1020 (below base) -> SRAM_ADDR = 0x3FFFE/0x3FFFF (wrapped offset), no hang.
